// File: rtl/issue_control.sv
// -----------------------------------------------------------------------------
// issue_control
//
// In-order, single-issue stage between decode and execute. It holds one decoded
// instruction and checks its source registers against the register-status
// scoreboard. It issues the instruction when there is no RAW hazard and the
// non-pipelined unit (2'b11, the divider) is not busy. When it issues, it
// claims rd in the scoreboard.
//
// Optional feature (build macro ISSUE_FORWARD_EN):
//   A pending operand counts as ready when its producer is in writeback this
//   cycle (sb_assN_row == 5'b00001). In that case out_fwdN is raised.
//   Without the macro, out_fwd1/out_fwd2 are tied to 0.
//
// Parameters:
//   PAYLOAD_W    width of the opaque payload passed to execute
//   BUSY_CYCLES  cycles unit 2'b11 blocks after an issue (0 = never blocks)
//
// Ports:
//   clock, reset (async, active-low)
//   flush                      synchronous kill of the held instruction
//   in_*                       decode side (valid/ready, decoded fields, payload)
//   sb_ass1_*, sb_ass2_*       scoreboard queries for held rs1 / rs2
//   sb_writeaddr, sb_registerunit, sb_enablewrite   scoreboard claim of rd
//   out_*                      execute side (valid/ready, unit, payload, bypass)
//   stall_cycles               saturating count of cycles a held op did not issue
// -----------------------------------------------------------------------------
module issue_control #(
    parameter int PAYLOAD_W   = 32,
    parameter int BUSY_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic                 in_use_rs1,
    input  logic                 in_use_rs2,
    input  logic [4:0]           in_rd,
    input  logic                 in_wr_rd,
    input  logic [1:0]           in_unit,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic [4:0]           sb_ass1_addr,
    input  logic                 sb_ass1_pending,
    input  logic [1:0]           sb_ass1_unit,
    input  logic [4:0]           sb_ass1_row,
    output logic [4:0]           sb_ass2_addr,
    input  logic                 sb_ass2_pending,
    input  logic [1:0]           sb_ass2_unit,
    input  logic [4:0]           sb_ass2_row,
    output logic [4:0]           sb_writeaddr,
    output logic [1:0]           sb_registerunit,
    output logic                 sb_enablewrite,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_unit,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 out_fwd1,
    output logic                 out_fwd2,
    output logic [15:0]          stall_cycles
);

    localparam int BUSY_W = (BUSY_CYCLES < 2) ? 1 : $clog2(BUSY_CYCLES + 1);
    localparam logic [BUSY_W-1:0] BUSY_LOAD = BUSY_W'(BUSY_CYCLES);
    localparam logic [1:0] UNIT_DIV = 2'b11;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [4:0]             rs1_q, rs1_d;
    logic [4:0]             rs2_q, rs2_d;
    logic [4:0]             rd_q, rd_d;
    logic [1:0]             unit_q, unit_d;
    logic [PAYLOAD_W-1:0]   payload_q, payload_d;
    logic                   use_rs1_q, use_rs1_d;
    logic                   use_rs2_q, use_rs2_d;
    logic                   wr_rd_q, wr_rd_d;
    logic [BUSY_W-1:0]      busy_cnt_q, busy_cnt_d;
    logic [15:0]            stall_q, stall_d;

    logic slot_valid;
    logic op1_ready, op2_ready;
    logic fwd1_case, fwd2_case;
    logic unit_block;
    logic issue_ok;
    logic fire;
    logic accept;

    // The unit fields of the scoreboard are only useful for trace. The row
    // fields matter only when bypassing is built in.
    logic unused_sb;
`ifdef ISSUE_FORWARD_EN
    assign unused_sb = ^{sb_ass1_unit, sb_ass2_unit};
`else
    assign unused_sb = ^{sb_ass1_unit, sb_ass2_unit, sb_ass1_row, sb_ass2_row};
`endif

    always_comb begin
        slot_valid = (state_q == S_FULL);

        // An operand is in its bypass case when the value is still pending
        // but the producer is in writeback this very cycle.
`ifdef ISSUE_FORWARD_EN
        fwd1_case = use_rs1_q && (rs1_q != 5'd0) && sb_ass1_pending && (sb_ass1_row == 5'b00001);
        fwd2_case = use_rs2_q && (rs2_q != 5'd0) && sb_ass2_pending && (sb_ass2_row == 5'b00001);
`else
        fwd1_case = 1'b0;
        fwd2_case = 1'b0;
`endif

        // r0 never carries a hazard, even if the scoreboard reports it pending.
        op1_ready = !use_rs1_q || (rs1_q == 5'd0) || !sb_ass1_pending || fwd1_case;
        op2_ready = !use_rs2_q || (rs2_q == 5'd0) || !sb_ass2_pending || fwd2_case;

        unit_block = (unit_q == UNIT_DIV) && (busy_cnt_q != '0);

        // flush overrides everything: nothing is issued or claimed that cycle.
        issue_ok = slot_valid && op1_ready && op2_ready && !unit_block && !flush;
        fire     = issue_ok && out_ready;
        in_ready = !flush && (!slot_valid || fire);
        accept   = in_valid && in_ready;

        // Slot state
        state_d = state_q;
        if (flush) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            state_d = S_FULL;
        end else if (fire) begin
            state_d = S_EMPTY;
        end

        // The held fields load only when a new instruction is accepted.
        rs1_d     = accept ? in_rs1     : rs1_q;
        rs2_d     = accept ? in_rs2     : rs2_q;
        rd_d      = accept ? in_rd      : rd_q;
        unit_d    = accept ? in_unit    : unit_q;
        payload_d = accept ? in_payload : payload_q;
        use_rs1_d = accept ? in_use_rs1 : use_rs1_q;
        use_rs2_d = accept ? in_use_rs2 : use_rs2_q;
        wr_rd_d   = accept ? in_wr_rd   : wr_rd_q;

        // The divider window keeps running through a flush: the unit is still busy.
        busy_cnt_d = busy_cnt_q;
        if (fire && (unit_q == UNIT_DIV)) begin
            busy_cnt_d = BUSY_LOAD;
        end else if (busy_cnt_q != '0) begin
            busy_cnt_d = busy_cnt_q - 1'b1;
        end

        stall_d = stall_q;
        if (slot_valid && !fire && !flush && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_EMPTY;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            unit_q     <= '0;
            payload_q  <= '0;
            use_rs1_q  <= 1'b0;
            use_rs2_q  <= 1'b0;
            wr_rd_q    <= 1'b0;
            busy_cnt_q <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            unit_q     <= unit_d;
            payload_q  <= payload_d;
            use_rs1_q  <= use_rs1_d;
            use_rs2_q  <= use_rs2_d;
            wr_rd_q    <= wr_rd_d;
            busy_cnt_q <= busy_cnt_d;
            stall_q    <= stall_d;
        end
    end

    assign sb_ass1_addr    = rs1_q;
    assign sb_ass2_addr    = rs2_q;
    assign sb_writeaddr    = rd_q;
    assign sb_registerunit = unit_q;
    // Writes to r0 are never recorded: no one ever waits on r0.
    assign sb_enablewrite  = fire && wr_rd_q && (rd_q != 5'd0);
    assign out_valid       = issue_ok;
    assign out_unit        = unit_q;
    assign out_payload     = payload_q;
    assign out_fwd1        = issue_ok && fwd1_case;
    assign out_fwd2        = issue_ok && fwd2_case;
    assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_issue_control.sv
// -----------------------------------------------------------------------------
// tb_issue_control
//
// Directed test of issue_control. A small scoreboard model sits beside the DUT.
// When a register is claimed, its producer row starts at 5'b10000. The row
// shifts right each cycle, so the register stays pending for five cycles.
// A force hook lets the bench report a register as pending without a claim.
// Expected values are worked out by hand for the default build. Where
// ISSUE_FORWARD_EN changes the result, the build macro selects the expected value.
// -----------------------------------------------------------------------------
module tb_issue_control;

    localparam int PAYLOAD_W = 32;

`ifdef ISSUE_FORWARD_EN
    localparam int RAW_STALLS = 4;
    localparam int EXP_FWD    = 1;
`else
    localparam int RAW_STALLS = 5;
    localparam int EXP_FWD    = 0;
`endif

    logic                 clock;
    logic                 reset;
    logic                 flush;
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic                 in_use_rs1;
    logic                 in_use_rs2;
    logic [4:0]           in_rd;
    logic                 in_wr_rd;
    logic [1:0]           in_unit;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [4:0]           sb_ass1_addr;
    logic                 sb_ass1_pending;
    logic [1:0]           sb_ass1_unit;
    logic [4:0]           sb_ass1_row;
    logic [4:0]           sb_ass2_addr;
    logic                 sb_ass2_pending;
    logic [1:0]           sb_ass2_unit;
    logic [4:0]           sb_ass2_row;
    logic [4:0]           sb_writeaddr;
    logic [1:0]           sb_registerunit;
    logic                 sb_enablewrite;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_unit;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 out_fwd1;
    logic                 out_fwd2;
    logic [15:0]          stall_cycles;

    int vectors     = 0;
    int miscompares = 0;

    // Scoreboard model
    logic [4:0] sb_row [32];
    logic [1:0] sb_unit [32];
    logic       force_en;
    logic [4:0] force_addr;

    issue_control #(
        .PAYLOAD_W  (PAYLOAD_W),
        .BUSY_CYCLES(4)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_use_rs1     (in_use_rs1),
        .in_use_rs2     (in_use_rs2),
        .in_rd          (in_rd),
        .in_wr_rd       (in_wr_rd),
        .in_unit        (in_unit),
        .in_payload     (in_payload),
        .sb_ass1_addr   (sb_ass1_addr),
        .sb_ass1_pending(sb_ass1_pending),
        .sb_ass1_unit   (sb_ass1_unit),
        .sb_ass1_row    (sb_ass1_row),
        .sb_ass2_addr   (sb_ass2_addr),
        .sb_ass2_pending(sb_ass2_pending),
        .sb_ass2_unit   (sb_ass2_unit),
        .sb_ass2_row    (sb_ass2_row),
        .sb_writeaddr   (sb_writeaddr),
        .sb_registerunit(sb_registerunit),
        .sb_enablewrite (sb_enablewrite),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_unit       (out_unit),
        .out_payload    (out_payload),
        .out_fwd1       (out_fwd1),
        .out_fwd2       (out_fwd2),
        .stall_cycles   (stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                sb_row[i]  <= 5'd0;
                sb_unit[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                sb_row[i] <= sb_row[i] >> 1;
            end
            if (sb_enablewrite) begin
                sb_row[sb_writeaddr]  <= 5'b10000;
                sb_unit[sb_writeaddr] <= sb_registerunit;
            end
        end
    end

    always_comb begin
        if (force_en && sb_ass1_addr == force_addr) begin
            sb_ass1_pending = 1'b1;
            sb_ass1_row     = 5'b10000;
        end else begin
            sb_ass1_pending = (sb_row[sb_ass1_addr] != 5'd0);
            sb_ass1_row     = sb_row[sb_ass1_addr];
        end
        if (force_en && sb_ass2_addr == force_addr) begin
            sb_ass2_pending = 1'b1;
            sb_ass2_row     = 5'b10000;
        end else begin
            sb_ass2_pending = (sb_row[sb_ass2_addr] != 5'd0);
            sb_ass2_row     = sb_row[sb_ass2_addr];
        end
        sb_ass1_unit = sb_unit[sb_ass1_addr];
        sb_ass2_unit = sb_unit[sb_ass2_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [4:0] rs1, input logic use1,
                         input logic [4:0] rs2, input logic use2,
                         input logic [4:0] rd, input logic wr,
                         input logic [1:0] unit, input logic [31:0] payload);
        in_valid   = 1'b1;
        in_rs1     = rs1;
        in_use_rs1 = use1;
        in_rs2     = rs2;
        in_use_rs2 = use2;
        in_rd      = rd;
        in_wr_rd   = wr;
        in_unit    = unit;
        in_payload = payload;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_use_rs1 = 1'b0;
        in_use_rs2 = 1'b0;
        in_wr_rd   = 1'b0;
    endtask

    // Called from a negedge. The reset pulse spans one rising edge.
    task automatic do_reset();
        idle();
        flush    = 1'b0;
        force_en = 1'b0;
        reset    = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        out_ready  = 1'b1;
        force_en   = 1'b0;
        force_addr = 5'd0;
        in_rs1     = 5'd0;
        in_rs2     = 5'd0;
        in_rd      = 5'd0;
        in_unit    = 2'd0;
        in_payload = '0;
        idle();

        // Reset state
        @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_enablewrite", sb_enablewrite, 0);
        check("rst_fwd1", out_fwd1, 0);
        check("rst_fwd2", out_fwd2, 0);
        check("rst_stall", stall_cycles, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Independent stream: r1, r2, r3, one issue per cycle
        offer(5'd0, 0, 5'd0, 0, 5'd1, 1, 2'd0, 32'hA1);
        @(negedge clock);
        check("ind_empty_valid", out_valid, 0);
        check("ind_empty_ready", in_ready, 1);
        tick();
        offer(5'd0, 0, 5'd0, 0, 5'd2, 1, 2'd0, 32'hA2);
        @(negedge clock);
        check("ind_r1_valid", out_valid, 1);
        check("ind_r1_claim", sb_enablewrite, 1);
        check("ind_r1_addr", sb_writeaddr, 1);
        check("ind_r1_payload", out_payload, 32'hA1);
        check("ind_r1_in_ready", in_ready, 1);
        tick();
        offer(5'd0, 0, 5'd0, 0, 5'd3, 1, 2'd0, 32'hA3);
        @(negedge clock);
        check("ind_r2_valid", out_valid, 1);
        check("ind_r2_addr", sb_writeaddr, 2);
        check("ind_r2_payload", out_payload, 32'hA2);
        tick();
        idle();
        @(negedge clock);
        check("ind_r3_valid", out_valid, 1);
        check("ind_r3_claim", sb_enablewrite, 1);
        check("ind_r3_addr", sb_writeaddr, 3);
        tick();
        @(negedge clock);
        check("ind_done_valid", out_valid, 0);
        check("ind_stall", stall_cycles, 0);
        do_reset();

        // RAW chain: r5 <- ; then a use of r5
        offer(5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd0, 32'hB1);
        @(negedge clock);
        check("raw_empty_valid", out_valid, 0);
        tick();
        offer(5'd5, 1, 5'd0, 0, 5'd6, 1, 2'd0, 32'hB2);
        @(negedge clock);
        check("raw_prod_valid", out_valid, 1);
        check("raw_prod_addr", sb_writeaddr, 5);
        tick();
        idle();
        for (int i = 0; i < RAW_STALLS; i++) begin
            @(negedge clock);
            check("raw_wait_valid", out_valid, 0);
            check("raw_wait_claim", sb_enablewrite, 0);
            check("raw_wait_query", sb_ass1_addr, 5);
            tick();
        end
        @(negedge clock);
        check("raw_issue_valid", out_valid, 1);
        check("raw_issue_fwd1", out_fwd1, EXP_FWD);
        check("raw_issue_claim", sb_enablewrite, 1);
        check("raw_issue_addr", sb_writeaddr, 6);
        check("raw_issue_payload", out_payload, 32'hB2);
        check("raw_issue_stall", stall_cycles, RAW_STALLS);
        tick();
        @(negedge clock);
        check("raw_after_valid", out_valid, 0);
        check("raw_after_stall", stall_cycles, RAW_STALLS);
        do_reset();

        // Divider busy window: div A, add C (unit 0), div B
        offer(5'd0, 0, 5'd0, 0, 5'd7, 1, 2'd3, 32'hC1);
        @(negedge clock);
        check("div_empty_valid", out_valid, 0);
        tick();
        offer(5'd0, 0, 5'd0, 0, 5'd9, 1, 2'd0, 32'hC2);
        @(negedge clock);
        check("divA_valid", out_valid, 1);
        check("divA_unit", out_unit, 3);
        check("divA_regunit", sb_registerunit, 3);
        tick();
        offer(5'd0, 0, 5'd0, 0, 5'd8, 1, 2'd3, 32'hC3);
        @(negedge clock);
        check("unit0_not_blocked", out_valid, 1);
        check("unit0_addr", sb_writeaddr, 9);
        tick();
        idle();
        // busy_cnt is 3, 2, 1 in these cycles; divB issues when it reaches 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("divB_blocked", out_valid, 0);
            check("divB_unit", out_unit, 3);
            tick();
        end
        @(negedge clock);
        check("divB_valid", out_valid, 1);
        check("divB_claim", sb_enablewrite, 1);
        check("divB_addr", sb_writeaddr, 8);
        check("divB_stall", stall_cycles, 3);
        tick();
        @(negedge clock);
        check("div_after_valid", out_valid, 0);
        do_reset();

        // Flush a held instruction with hazards clear and out_ready high
        offer(5'd0, 0, 5'd0, 0, 5'd10, 1, 2'd0, 32'hD1);
        @(negedge clock);
        check("fl_accept_ready", in_ready, 1);
        tick();
        idle();
        flush = 1'b1;
        @(negedge clock);
        check("fl_valid", out_valid, 0);
        check("fl_claim", sb_enablewrite, 0);
        check("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        @(negedge clock);
        check("fl_empty_valid", out_valid, 0);
        check("fl_empty_ready", in_ready, 1);
        check("fl_stall", stall_cycles, 0);
        do_reset();

        // r0 source reported pending, and an rd=0 writer
        force_en   = 1'b1;
        force_addr = 5'd0;
        offer(5'd0, 1, 5'd0, 1, 5'd0, 1, 2'd0, 32'hE1);
        tick();
        idle();
        @(negedge clock);
        check("r0_valid", out_valid, 1);
        check("r0_claim", sb_enablewrite, 0);
        check("r0_stall", stall_cycles, 0);
        tick();
        // Then a real stall on r11, cut short by reset
        force_addr = 5'd11;
        offer(5'd11, 1, 5'd0, 0, 5'd12, 1, 2'd0, 32'hE2);
        @(negedge clock);
        check("rs_empty_valid", out_valid, 0);
        tick();
        idle();
        @(negedge clock);
        check("rs_wait_valid", out_valid, 0);
        tick();
        @(negedge clock);
        check("rs_wait_stall", stall_cycles, 1);
        reset = 1'b0;
        #1;
        check("rs_mid_valid", out_valid, 0);
        check("rs_mid_ready", in_ready, 1);
        check("rs_mid_claim", sb_enablewrite, 0);
        check("rs_mid_stall", stall_cycles, 0);
        check("rs_mid_fwd1", out_fwd1, 0);
        @(posedge clock);
        #1;
        reset    = 1'b1;
        force_en = 1'b0;
        @(negedge clock);
        check("rs_after_valid", out_valid, 0);
        check("rs_after_stall", stall_cycles, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
